cdd_sector_tx: RTL and testbench

//  Drive-side transmitter for the CD data port: emits 2352-byte raw sectors as 1176 16-bit words on CD_D with a CD_CK strobe per word.
//  Per sector: 6 sync words, 2 header words built from an internal BCD MSF counter, then 1168 payload words pulled from a valid/ready source.

---
 rtl/cdd_sector_tx.sv | 200 ++++++++++++++++++++
 tb/tb_cdd_sector_tx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdd_sector_tx.sv
// cdd_sector_tx: CD drive-side transmitter. Streams 2352-byte raw sectors as 1176 16-bit
// words on CD_D with one CD_CK strobe per word, paced by a fractional word-rate generator.
// Each sector is 6 sync words, 2 header words from a BCD MSF counter, then 1168 payload words.
// Optional feature: define CDD_SCRAMBLE_EN to XOR words 6..1175 with the ECMA-130 scrambler.
module cdd_sector_tx #(
    parameter int unsigned CLK_HZ  = 53693175,
    parameter int unsigned WORD_HZ = 88200,
    parameter int unsigned CK_HIGH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic [23:0] START_MSF,
    input  logic [7:0]  MODE,
    input  logic        SPEED2X,
    input  logic [15:0] S_DATA,
    input  logic        S_VALID,
    output logic        S_READY,
    output logic [15:0] CD_D,
    output logic        CD_CK,
    output logic        BUSY,
    output logic [23:0] CUR_MSF,
    output logic        SECT_DONE,
    output logic        UNDERRUN
);

    typedef enum logic [1:0] {StIdle, StSync, StHdr, StData} state_t;

    localparam logic [26:0] Inc1x   = 27'(WORD_HZ);
    localparam logic [26:0] Inc2x   = 27'(2 * WORD_HZ);
    localparam logic [27:0] ClkHz   = 28'(CLK_HZ);
    localparam logic [2:0]  CkLoad  = 3'(CK_HIGH - 1);
    localparam logic [10:0] LastIdx = 11'd1175;

    state_t      state;
    logic [26:0] acc;
    logic [10:0] idx;
    logic [2:0]  ck_cnt;
    logic [26:0] inc;
    logic [27:0] sum;
    logic        tick;
    logic [15:0] word;
    logic [15:0] word_out;

    // BCD digit-pair increment; caller handles the wrap values
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Next MSF address: frame 74 -> 00 carries to sec, sec 59 -> 00 carries to min, min wraps at 99
    function automatic logic [23:0] msf_next(input logic [23:0] m);
        logic [7:0] mi;
        logic [7:0] se;
        logic [7:0] fr;
        mi = m[23:16];
        se = m[15:8];
        fr = m[7:0];
        if (fr == 8'h74) begin
            fr = 8'h00;
            if (se == 8'h59) begin
                se = 8'h00;
                mi = (mi == 8'h99) ? 8'h00 : bcd_inc(mi);
            end else begin
                se = bcd_inc(se);
            end
        end else begin
            fr = bcd_inc(fr);
        end
        return {mi, se, fr};
    endfunction

    // Fractional rate generator: a word slot is due whenever the accumulator crosses CLK_HZ
    always_comb begin
        inc  = SPEED2X ? Inc2x : Inc1x;
        sum  = {1'b0, acc} + {1'b0, inc};
        tick = (state != StIdle) && (sum >= ClkHz);
    end

    // Word for the current slot before optional scrambling
    always_comb begin
        word = 16'h0000;
        unique case (state)
            StSync: begin
                if (idx == 11'd0) begin
                    word = 16'h00FF;
                end else if (idx == 11'd5) begin
                    word = 16'hFF00;
                end else begin
                    word = 16'hFFFF;
                end
            end
            StHdr:   word = (idx == 11'd6) ? CUR_MSF[23:8] : {CUR_MSF[7:0], MODE};
            StData:  word = S_VALID ? S_DATA : 16'h0000;
            default: word = 16'h0000;
        endcase
    end

`ifdef CDD_SCRAMBLE_EN
    logic [14:0] lfsr;
    logic [14:0] lfsr_seed;
    logic [14:0] lfsr_tmp;
    logic [14:0] lfsr_next;
    logic [15:0] scr_mask;

    // 16 scrambler bits per word: first 8 outputs fill [15:8] LSB first, next 8 fill [7:0]
    always_comb begin
        lfsr_seed = (idx == 11'd6) ? 15'h0001 : lfsr;
        lfsr_tmp  = lfsr_seed;
        scr_mask  = 16'h0000;
        for (int b = 0; b < 16; b++) begin
            scr_mask[4'(b + 8)] = lfsr_tmp[0];
            lfsr_tmp = {lfsr_tmp[0] ^ lfsr_tmp[1], lfsr_tmp[14:1]};
        end
        lfsr_next = lfsr_tmp;
        word_out  = ((state == StHdr) || (state == StData)) ? (word ^ scr_mask) : word;
    end

    // Scrambler advances on every header/payload slot, underrun slots included
    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr <= 15'h0001;
        end else if (tick && !STOP && (state != StSync)) begin
            lfsr <= lfsr_next;
        end
    end
`else
    assign word_out = word;
`endif

    // Pop happens in the tick cycle itself; STOP or RST in that cycle cancels it
    assign S_READY = tick && (state == StData) && S_VALID && !STOP && !RST;
    assign BUSY    = (state != StIdle);

    // Sector FSM with registered word, strobe, MSF and status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= StIdle;
            acc       <= '0;
            idx       <= '0;
            ck_cnt    <= '0;
            CD_D      <= '0;
            CD_CK     <= 1'b0;
            CUR_MSF   <= '0;
            SECT_DONE <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else begin
            SECT_DONE <= 1'b0;
            if (CD_CK) begin
                if (ck_cnt == 3'd0) begin
                    CD_CK <= 1'b0;
                end else begin
                    ck_cnt <= ck_cnt - 3'd1;
                end
            end
            if (STOP) begin
                // CD_D and CUR_MSF deliberately hold; the partial sector is dropped
                state <= StIdle;
                idx   <= '0;
                CD_CK <= 1'b0;
            end else if (state == StIdle) begin
                if (START) begin
                    CUR_MSF  <= START_MSF;
                    UNDERRUN <= 1'b0;
                    state    <= StSync;
                    idx      <= '0;
                    acc      <= '0;
                end
            end else begin
                acc <= tick ? 27'(sum - ClkHz) : sum[26:0];
                if (tick) begin
                    CD_D   <= word_out;
                    CD_CK  <= 1'b1;
                    ck_cnt <= CkLoad;
                    idx    <= idx + 11'd1;
                    unique case (state)
                        StSync: if (idx == 11'd5) state <= StHdr;
                        StHdr:  if (idx == 11'd7) state <= StData;
                        StData: begin
                            if (!S_VALID) begin
                                UNDERRUN <= 1'b1;
                            end
                            if (idx == LastIdx) begin
                                idx       <= '0;
                                state     <= StSync;
                                SECT_DONE <= 1'b1;
                                CUR_MSF   <= msf_next(CUR_MSF);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cdd_sector_tx.sv
// Scoreboard bench for cdd_sector_tx: expected words and MSF values are queued when a
// sector is started; a negedge monitor pops them on each CD_CK rise and on SECT_DONE.
`timescale 1ns/1ps
module tb_cdd_sector_tx;

    // Scaled clock so whole sectors fit in a short run: 8.5 clk/word at 1x, 4.25 at 2x
    localparam int unsigned CLK_HZ  = 750000;
    localparam int unsigned WORD_HZ = 88200;
    localparam int unsigned CK_HIGH = 2;

    logic        clk = 1'b0;
    logic        rst, start, stop, speed2x, s_valid;
    logic [23:0] start_msf;
    logic [7:0]  mode;
    logic [15:0] s_data;
    logic        s_ready, cd_ck, busy, sect_done, underrun;
    logic [15:0] cd_d;
    logic [23:0] cur_msf;

    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    int   sec_strobes = 0;
    int   pops = 0;
    int   done_cnt = 0;
    int   hi_len = 0;
    bit   chk_words = 1'b1;
    bit   ck_prev = 1'b0;
    bit   src_en = 1'b1;
    bit   pop_seen = 1'b0;
    logic [15:0] src_data = 16'h0000;
    logic [15:0] exp_q[$];
    logic [23:0] msf_q[$];

    cdd_sector_tx #(
        .CLK_HZ (CLK_HZ),
        .WORD_HZ(WORD_HZ),
        .CK_HIGH(CK_HIGH)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .STOP     (stop),
        .START_MSF(start_msf),
        .MODE     (mode),
        .SPEED2X  (speed2x),
        .S_DATA   (s_data),
        .S_VALID  (s_valid),
        .S_READY  (s_ready),
        .CD_D     (cd_d),
        .CD_CK    (cd_ck),
        .BUSY     (busy),
        .CUR_MSF  (cur_msf),
        .SECT_DONE(sect_done),
        .UNDERRUN (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, wanted %h (strobe %0d, t=%0t)", name, act, exp,
                     strobe_cnt, $time);
        end
    endtask

    // Source: holds S_DATA until popped, then presents the next incrementing word
    initial begin
        s_valid = 1'b0;
        s_data  = 16'h0000;
        forever begin
            @(negedge clk);
            pop_seen = (s_ready === 1'b1);
            @(posedge clk);
            #1;
            if (pop_seen) src_data = src_data + 16'd1;
            s_valid = src_en;
            s_data  = src_data;
        end
    end

    // Monitor: word scoreboard, strobe width, pop count and sector-end checks
    always @(negedge clk) begin
        if (cd_ck === 1'b1 && !ck_prev) begin
            strobe_cnt++;
            sec_strobes++;
            hi_len = 1;
            if (chk_words) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: cd_d=%h, wanted no strobe (t=%0t)", cd_d,
                             $time);
                end else begin
                    check("cd_d", 32'(cd_d), 32'(exp_q.pop_front()));
                end
            end
        end else if (cd_ck === 1'b1) begin
            hi_len++;
        end else if (ck_prev && busy === 1'b1) begin
            check("ck_high", 32'(hi_len), 32'(CK_HIGH));
        end
        ck_prev = (cd_ck === 1'b1);
        if (s_ready === 1'b1) pops++;
        if (sect_done === 1'b1) begin
            done_cnt++;
            check("sector_len", 32'(sec_strobes), 32'd1176);
            sec_strobes = 0;
            if (msf_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sect_done: cur_msf=%h, wanted no sector end", cur_msf);
            end else begin
                check("cur_msf", 32'(cur_msf), 32'(msf_q.pop_front()));
            end
        end
    end

    task automatic push_hdr(input logic [23:0] msf, input logic [7:0] md);
        exp_q.push_back(16'h00FF);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hFF00);
        exp_q.push_back(msf[23:8]);
        exp_q.push_back({msf[7:0], md});
    endtask

    task automatic set_source(input bit en, input logic [15:0] d);
        @(posedge clk);
        #1;
        src_en   = en;
        src_data = d;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [23:0] msf, input logic [7:0] md);
        @(posedge clk);
        #1;
        start_msf   = msf;
        mode        = md;
        start       = 1'b1;
        sec_strobes = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int limit, input string name);
        int n = 0;
        while (strobe_cnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (strobe_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: strobes=%0d, wanted %0d within %0d cycles", name, strobe_cnt,
                     target, limit);
        end
    endtask

    task automatic wait_done(input int target, input int limit, input string name);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: sect_done count=%0d, wanted %0d within %0d cycles", name,
                     done_cnt, target, limit);
        end
    endtask

    task automatic check_rate(input string name, input int win, input int mult);
        int     base;
        int     cnt;
        longint exact;
        longint lo;
        longint hi;
        base = strobe_cnt;
        repeat (win) @(negedge clk);
        #1;
        cnt   = strobe_cnt - base;
        exact = longint'(win) * longint'(WORD_HZ) * longint'(mult);
        lo    = (exact - longint'(CLK_HZ) + longint'(CLK_HZ) - 1) / longint'(CLK_HZ);
        hi    = (exact + longint'(CLK_HZ)) / longint'(CLK_HZ);
        checks++;
        if (longint'(cnt) < lo || longint'(cnt) > hi) begin
            errors++;
            $display("FAIL %s: strobes=%0d in %0d cycles, wanted %0d..%0d", name, cnt, win, lo,
                     hi);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pbase;
        int dbase;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        speed2x   = 1'b0;
        start_msf = 24'h000000;
        mode      = 8'h00;

        // T1: reset values and silence while idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cd_d", 32'(cd_d), 32'h0);
        check("rst_cd_ck", 32'(cd_ck), 32'h0);
        check("rst_s_ready", 32'(s_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cur_msf", 32'(cur_msf), 32'h0);
        check("rst_sect_done", 32'(sect_done), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        base = strobe_cnt;
        repeat (10000) @(negedge clk);
        check("idle_strobes", 32'(strobe_cnt - base), 32'h0);

        // T2: one full 1x sector from 00:02:00, incrementing payload from 0
        set_source(1'b1, 16'h0000);
        push_hdr(24'h000200, 8'h01);
        for (int i = 0; i < 1168; i++) exp_q.push_back(16'(i));
        msf_q.push_back(24'h000201);
        pbase = pops;
        dbase = done_cnt;
        pulse_start(24'h000200, 8'h01);
        check("t2_busy", 32'(busy), 32'h1);
        wait_done(dbase + 1, 20000, "t2_done");
        pulse_stop();
        check("t2_pops", 32'(pops - pbase), 32'd1168);
        check("t2_queue_left", 32'(exp_q.size()), 32'h0);

        // T3: word rate at 1x then 2x, words not scoreboarded
        chk_words = 1'b0;
        set_source(1'b1, 16'h0000);
        msf_q.push_back(24'h000001);
        dbase = done_cnt;
        base  = strobe_cnt;
        pulse_start(24'h000000, 8'h01);
        wait_strobes(base + 1, 100, "t3_first");
        check_rate("rate_1x", 8500, 1);
        @(posedge clk);
        #1;
        speed2x = 1'b1;
        repeat (20) @(negedge clk);
        check_rate("rate_2x", 4250, 2);
        pulse_stop();
        check("t3_sectors", 32'(done_cnt - dbase), 32'd1);
        chk_words = 1'b1;

        // T4: MSF wrap cases at 2x
        set_source(1'b1, 16'h0000);
        push_hdr(24'h995974, 8'h02);
        for (int i = 0; i < 1168; i++) exp_q.push_back(16'(i));
        msf_q.push_back(24'h000000);
        dbase = done_cnt;
        pulse_start(24'h995974, 8'h02);
        wait_done(dbase + 1, 10000, "t4a_done");
        pulse_stop();

        set_source(1'b1, 16'h0000);
        push_hdr(24'h000074, 8'h02);
        for (int i = 0; i < 1168; i++) exp_q.push_back(16'(i));
        msf_q.push_back(24'h000100);
        dbase = done_cnt;
        pulse_start(24'h000074, 8'h02);
        wait_done(dbase + 1, 10000, "t4b_done");
        pulse_stop();

        // T5: source empty for payload slots idx 8..9
        set_source(1'b0, 16'h0000);
        push_hdr(24'h000500, 8'h01);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 1166; i++) exp_q.push_back(16'(i));
        msf_q.push_back(24'h000501);
        pbase = pops;
        dbase = done_cnt;
        base  = strobe_cnt;
        pulse_start(24'h000500, 8'h01);
        wait_strobes(base + 10, 200, "t5_hole");
        check("t5_pops_in_hole", 32'(pops - pbase), 32'h0);
        src_en = 1'b1;
        wait_done(dbase + 1, 10000, "t5_done");
        pulse_stop();
        @(negedge clk);
        check("t5_underrun", 32'(underrun), 32'h1);
        check("t5_pops", 32'(pops - pbase), 32'd1166);

        // T6: STOP together with START at idx 500, then restart
        set_source(1'b0, 16'h0000);
        push_hdr(24'h001000, 8'h01);
        for (int i = 0; i < 492; i++) exp_q.push_back(16'h0000);
        base = strobe_cnt;
        pulse_start(24'h001000, 8'h01);
        wait_strobes(base + 500, 5000, "t6_idx500");
        @(posedge clk);
        #1;
        stop      = 1'b1;
        start     = 1'b1;
        start_msf = 24'h002000;
        @(posedge clk);
        #1;
        stop  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_cd_ck", 32'(cd_ck), 32'h0);
        check("t6_underrun_held", 32'(underrun), 32'h1);
        check("t6_cur_msf_held", 32'(cur_msf), 32'h001000);
        check("t6_cd_d_held", 32'(cd_d), 32'h0000);
        check("t6_queue_left", 32'(exp_q.size()), 32'h0);
        base = strobe_cnt;
        repeat (300) @(negedge clk);
        check("t6_no_strobes", 32'(strobe_cnt - base), 32'h0);

        set_source(1'b1, 16'h1234);
        push_hdr(24'h002000, 8'h01);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1234 + 16'(i));
        base = strobe_cnt;
        pulse_start(24'h002000, 8'h01);
        @(negedge clk);
        check("t6_restart_busy", 32'(busy), 32'h1);
        check("t6_restart_underrun", 32'(underrun), 32'h0);
        wait_strobes(base + 12, 200, "t6_restart");
        pulse_stop();
        check("t6_restart_queue_left", 32'(exp_q.size()), 32'h0);

        // RST mid-sector returns every output to its reset value
        set_source(1'b1, 16'h0000);
        push_hdr(24'h003000, 8'h01);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        base = strobe_cnt;
        pulse_start(24'h003000, 8'h01);
        wait_strobes(base + 10, 200, "rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstm_cd_d", 32'(cd_d), 32'h0);
        check("rstm_cd_ck", 32'(cd_ck), 32'h0);
        check("rstm_busy", 32'(busy), 32'h0);
        check("rstm_cur_msf", 32'(cur_msf), 32'h0);
        check("rstm_underrun", 32'(underrun), 32'h0);
        base = strobe_cnt;
        repeat (100) @(negedge clk);
        check("rstm_no_strobes", 32'(strobe_cnt - base), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
